// File: rtl/alu_pkg.sv
// Shared opcode, state and latency definitions for the ALU operation sequencer.
package alu_pkg;

  localparam int RESULT_W = 16;
  localparam int LAT_W    = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4,
    OP_EQ  = 3'd5,
    OP_GT  = 3'd6,
    OP_LT  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of EXEC cycles the combinational cells need for a given opcode.
  function automatic logic [LAT_W-1:0] op_latency(input op_t op,
                                                  input logic [LAT_W-1:0] mul_lat,
                                                  input logic [LAT_W-1:0] div_lat);
    logic [LAT_W-1:0] lat;
    case (op)
      OP_MUL:         lat = mul_lat;
      OP_DIV, OP_MOD: lat = div_lat;
      default:        lat = 8'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a client (master) and the sequencer (slave).
// The out_err signal exists only when ALU_ERR_FLAG_EN is defined.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  op_t                 in_op;
  logic [7:0]          in_a;
  logic [7:0]          in_b;
  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_result;
  logic                out_zero;
`ifdef ALU_ERR_FLAG_EN
  logic                out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero
  );
`endif

endinterface

// File: rtl/alu_datapath.sv
// Combinational 8-bit arithmetic cells muxed to a 16-bit result, plus a divide-by-zero flag.
module alu_datapath
  import alu_pkg::*;
(
  input  op_t                 op,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  output logic [RESULT_W-1:0] result,
  output logic                div_zero
);

  logic [8:0]  sum_s;
  logic [8:0]  diff_s;
  logic [15:0] prod_s;
  logic [7:0]  quot_s;
  logic [7:0]  rem_s;
  logic        b_zero_s;

  assign b_zero_s = (b == 8'd0);
  assign sum_s    = {1'b0, a} + {1'b0, b};
  // Bit 8 of the 9-bit difference is the borrow out.
  assign diff_s   = {1'b0, a} - {1'b0, b};
  assign prod_s   = {8'h00, a} * {8'h00, b};
  assign quot_s   = b_zero_s ? 8'd0 : (a / b);
  assign rem_s    = b_zero_s ? 8'd0 : (a % b);

  always_comb begin
    result   = 16'h0000;
    div_zero = 1'b0;
    case (op)
      OP_ADD: result = {7'b0, sum_s};
      OP_SUB: result = {7'b0, diff_s};
      OP_MUL: result = prod_s;
      OP_DIV: begin
        result   = {8'h00, quot_s};
        div_zero = b_zero_s;
      end
      OP_MOD: begin
        result   = {8'h00, rem_s};
        div_zero = b_zero_s;
      end
      OP_EQ:  result = (a == b) ? 16'h0001 : 16'h0000;
      OP_GT:  result = (a > b)  ? 16'h0001 : 16'h0000;
      OP_LT:  result = (a < b)  ? 16'h0001 : 16'h0000;
      default: begin
        result   = 16'h0000;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer: latches a request, waits the per-op multicycle budget, then
// holds a registered result until taken. Optional out_err under ALU_ERR_FLAG_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [LAT_W-1:0] MUL_LAT_C = MUL_LAT[LAT_W-1:0];
  localparam logic [LAT_W-1:0] DIV_LAT_C = DIV_LAT[LAT_W-1:0];

  state_t              state_r;
  state_t              state_s;
  logic                accept_s;
  logic                capture_s;
  logic                handshake_s;
  op_t                 op_r;
  logic [7:0]          a_r;
  logic [7:0]          b_r;
  logic [LAT_W-1:0]    cnt_r;
  logic                in_ready_r;
  logic                busy_r;
  logic                out_valid_r;
  logic [RESULT_W-1:0] out_result_r;
  logic                out_zero_r;
  logic [COUNT_W-1:0]  op_count_r;
  logic [RESULT_W-1:0] dp_result_s;
  logic                dp_div_zero_s;

  alu_datapath u_datapath (
    .op       (op_r),
    .a        (a_r),
    .b        (b_r),
    .result   (dp_result_s),
    .div_zero (dp_div_zero_s)
  );

  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = ST_EXEC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == 8'd0) begin
          capture_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s   = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          handshake_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      op_count_r  <= '0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      if (handshake_s) begin
        op_count_r <= op_count_r + 1'b1;
      end else begin
        op_count_r <= op_count_r;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= OP_ADD;
      a_r   <= 8'h00;
      b_r   <= 8'h00;
      cnt_r <= 8'd0;
    end else if (accept_s) begin
      op_r  <= bus.in_op;
      a_r   <= bus.in_a;
      b_r   <= bus.in_b;
      cnt_r <= op_latency(bus.in_op, MUL_LAT_C, DIV_LAT_C) - 8'd1;
    end else if ((state_r == ST_EXEC) && (cnt_r != 8'd0)) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef ALU_ERR_FLAG_EN
  logic out_err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result_r <= 16'h0000;
      out_zero_r   <= 1'b1;
      out_err_r    <= 1'b0;
    end else if (capture_s) begin
      out_result_r <= dp_result_s;
      out_zero_r   <= (dp_result_s == 16'h0000);
      out_err_r    <= dp_div_zero_s;
    end else begin
      out_result_r <= out_result_r;
      out_zero_r   <= out_zero_r;
      out_err_r    <= out_err_r;
    end
  end

  assign bus.out_err = out_err_r;
`else
  // A divide by zero already yields a zero result; the flag only reinforces out_zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result_r <= 16'h0000;
      out_zero_r   <= 1'b1;
    end else if (capture_s) begin
      out_result_r <= dp_result_s;
      out_zero_r   <= (dp_result_s == 16'h0000) | dp_div_zero_s;
    end else begin
      out_result_r <= out_result_r;
      out_zero_r   <= out_zero_r;
    end
  end
`endif

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_zero   = out_zero_r;
  assign busy           = busy_r;
  assign op_count       = op_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (MUL_LAT=2, DIV_LAT=4, COUNT_W=8).
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] op_count;
  int         checks;
  int         failures;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MUL_LAT (2),
    .DIV_LAT (4),
    .COUNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs during EXEC, and check the result at its first valid cycle.
  task automatic run_op(input string tag, input op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int lat, input bit exp_err, input bit quiet);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_rdy"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = OP_SUB;
    bus.in_a     = ~a;
    bus.in_b     = b + 8'd1;
    if (!quiet) begin
      check_eq({tag, "_rdy_lo"}, bus.in_ready, 1'b0);
      check_eq({tag, "_busy"}, busy, 1'b1);
    end
    cyc = 0;
    while (!bus.out_valid && cyc < 64) begin
      bus.in_valid = cyc[0];
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat"}, cyc, lat);
    check_eq({tag, "_res"}, bus.out_result, exp);
    if (!quiet) begin
      check_eq({tag, "_zero"}, bus.out_zero, (exp == 16'h0000));
`ifdef ALU_ERR_FLAG_EN
      check_eq({tag, "_err"}, bus.out_err, exp_err);
`else
      if (exp_err) check_eq({tag, "_dz"}, bus.out_zero, 1'b1);
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_result", bus.out_result, 16'h0000);
    check_eq("rst_zero", bus.out_zero, 1'b1);
    check_eq("rst_count", op_count, 8'd0);
    check_eq("rst_busy", busy, 1'b0);
`ifdef ALU_ERR_FLAG_EN
    check_eq("rst_err", bus.out_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", bus.in_ready, 1'b1);

    run_op("add", OP_ADD, 8'hF0, 8'h20, 16'h0110, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("add_cnt", op_count, 8'd1);
    run_op("mul", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 2, 1'b0, 1'b0);
    run_op("div0", OP_DIV, 8'd7, 8'd0, 16'h0000, 4, 1'b1, 1'b0);
    run_op("mod", OP_MOD, 8'd7, 8'd3, 16'h0001, 4, 1'b0, 1'b0);
    run_op("div", OP_DIV, 8'd200, 8'd7, 16'h001C, 4, 1'b0, 1'b0);
    run_op("eq", OP_EQ, 8'h5A, 8'h5A, 16'h0001, 1, 1'b0, 1'b0);
    run_op("gt", OP_GT, 8'h10, 8'h80, 16'h0000, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("mix_cnt", op_count, 8'd7);

    // Stall the consumer: result must hold until out_ready rises.
    bus.out_ready = 1'b0;
    run_op("sub", OP_SUB, 8'd3, 8'd5, 16'h01FE, 1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("sub_hold_v", bus.out_valid, 1'b1);
    check_eq("sub_hold_r", bus.out_result, 16'h01FE);
    check_eq("sub_hold_c", op_count, 8'd7);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("sub_taken", bus.out_valid, 1'b0);
    check_eq("sub_cnt", op_count, 8'd8);
    run_op("lt", OP_LT, 8'd3, 8'd5, 16'h0001, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("lt_cnt", op_count, 8'd9);

    // Reset in the second EXEC cycle of a DIV discards it.
    bus.in_valid = 1'b1;
    bus.in_op    = OP_DIV;
    bus.in_a     = 8'd9;
    bus.in_b     = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("rx_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rx_valid", bus.out_valid, 1'b0);
    check_eq("rx_busy", busy, 1'b0);
    check_eq("rx_count", op_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rx_no_out", bus.out_valid, 1'b0);
    check_eq("rx_result", bus.out_result, 16'h0000);
    run_op("add11", OP_ADD, 8'd1, 8'd1, 16'h0002, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("add11_cnt", op_count, 8'd1);

    // 257 more ADDs: count goes 1 -> 255 -> 0 -> 2.
    for (int i = 0; i < 257; i++) begin
      logic [7:0] va;
      va = i[7:0];
      run_op("bb", OP_ADD, va, 8'd3, {8'h00, va} + 16'h0003, 1, 1'b0, 1'b1);
      if (i == 253) begin
        @(negedge clk);
        check_eq("wrap_255", op_count, 8'd255);
      end
      if (i == 254) begin
        @(negedge clk);
        check_eq("wrap_0", op_count, 8'd0);
      end
    end
    @(negedge clk);
    check_eq("wrap_end", op_count, 8'd2);
    check_eq("end_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
